// File: rtl/fifo_frame_pkg.sv
// Shared constants, frame type codes and FSM state encoding for the FIFO frame streamer.
package fifo_frame_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [3:0] TYPE_BOOT = 4'h0;
    localparam logic [3:0] TYPE_USER = 4'h1;

    typedef enum logic [2:0] {
        IDLE,
        HDR0,
        HDR1,
        HDR2,
        FETCH,
        PAY,
        CSUM
    } state_t;

endpackage

// File: rtl/fifo_frame_streamer_bitram.sv
// 8192x1 simple dual-port bit memory with a registered read port.
// A read of an address written in the same cycle returns the old bit.
module fifo_bitram #(
    parameter int AW = 13
) (
    input  logic          clk,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic          wr_data_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic          rd_data_o
);

    localparam int DEPTH = 1 << AW;

    logic mem_q [0:DEPTH-1];
    logic rd_data_q;

    // Contents are intentionally left out of reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        rd_data_q <= mem_q[rd_addr_i];
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fifo_frame_streamer.sv
// Captures the loader's bit-serial page image and, on each send strobe, streams it
// out as A5 / type+page / page / payload / checksum over a valid/ready handshake.
module fifo_frame_streamer
    import fifo_frame_pkg::*;
#(
    parameter int BOOT_BYTES = 1024,
    parameter int USER_BYTES = 64
) (
    input  logic        MCLK,
    input  logic        RST,
    input  logic        nFIFOBUFWRCLKEN,
    input  logic [12:0] FIFOBUFWRADDR,
    input  logic        FIFOBUFWRDATA,
    input  logic        nFIFOSENDBOOT,
    input  logic        nFIFOSENDUSER,
    input  logic [11:0] FIFORELPAGE,
    output logic [7:0]  TXDATA,
    output logic        TXVALID,
    input  logic        TXREADY,
    output logic        BUSY,
    output logic        OVERRUN
);

    localparam logic [9:0] BOOT_LAST = 10'(BOOT_BYTES - 1);
    localparam logic [9:0] USER_LAST = 10'(USER_BYTES - 1);

    state_t      state_q, state_d;
    logic        prev_boot_q, prev_user_q;
    logic        is_user_q, is_user_d;
    logic [11:0] relpage_q, relpage_d;
    logic [9:0]  last_k_q, last_k_d;
    logic [9:0]  k_q, k_d;
    logic [3:0]  bit_q, bit_d;
    logic [7:0]  byte_q, byte_d;
    logic [7:0]  csum_q, csum_d;
    logic        overrun_q, overrun_d;

    logic        req_boot, req_user, hs, rd_bit;
    logic [12:0] rd_addr;

    assign req_boot = !nFIFOSENDBOOT && prev_boot_q;
    assign req_user = !nFIFOSENDUSER && prev_user_q;
    assign hs       = TXVALID && TXREADY;
    assign rd_addr  = {k_q, bit_q[2:0]};

    fifo_bitram #(.AW(13)) u_bitram (
        .clk      (MCLK),
        .wr_en_i  (!nFIFOBUFWRCLKEN),
        .wr_addr_i(FIFOBUFWRADDR),
        .wr_data_i(FIFOBUFWRDATA),
        .rd_addr_i(rd_addr),
        .rd_data_o(rd_bit)
    );

    always_comb begin
        state_d   = state_q;
        is_user_d = is_user_q;
        relpage_d = relpage_q;
        last_k_d  = last_k_q;
        k_d       = k_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        csum_d    = csum_q;
        // Drops: any request while busy, or the user strobe losing a simultaneous race.
        overrun_d = overrun_q
                  | ((state_q != IDLE) && (req_boot || req_user))
                  | ((state_q == IDLE) && req_boot && req_user);

        case (state_q)
            IDLE: begin
                if (req_boot || req_user) begin
                    is_user_d = !req_boot;
                    relpage_d = FIFORELPAGE;
                    last_k_d  = req_boot ? BOOT_LAST : USER_LAST;
                    k_d       = 10'd0;
                    csum_d    = 8'd0;
                    state_d   = HDR0;
                end
            end
            HDR0: if (hs) state_d = HDR1;
            HDR1: if (hs) state_d = HDR2;
            HDR2: begin
                if (hs) begin
                    bit_d   = 4'd0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                // Read data lags the address by one cycle, so bit (bit_q-1) lands now.
                bit_d = bit_q + 4'd1;
                if (bit_q != 4'd0) begin
                    byte_d = {rd_bit, byte_q[7:1]};
                end
                if (bit_q == 4'd8) begin
                    state_d = PAY;
                end
            end
            PAY: begin
                if (hs) begin
                    csum_d = csum_q + byte_q;
                    if (k_q == last_k_q) begin
                        state_d = CSUM;
                    end else begin
                        k_d     = k_q + 10'd1;
                        bit_d   = 4'd0;
                        state_d = FETCH;
                    end
                end
            end
            CSUM: if (hs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge MCLK) begin
        if (RST) begin
            state_q     <= IDLE;
            prev_boot_q <= 1'b1;
            prev_user_q <= 1'b1;
            is_user_q   <= 1'b0;
            relpage_q   <= 12'd0;
            last_k_q    <= 10'd0;
            k_q         <= 10'd0;
            bit_q       <= 4'd0;
            byte_q      <= 8'd0;
            csum_q      <= 8'd0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_boot_q <= nFIFOSENDBOOT;
            prev_user_q <= nFIFOSENDUSER;
            is_user_q   <= is_user_d;
            relpage_q   <= relpage_d;
            last_k_q    <= last_k_d;
            k_q         <= k_d;
            bit_q       <= bit_d;
            byte_q      <= byte_d;
            csum_q      <= csum_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        TXDATA  = 8'h00;
        TXVALID = 1'b1;
        case (state_q)
            HDR0:    TXDATA = SYNC_BYTE;
            HDR1:    TXDATA = {(is_user_q ? TYPE_USER : TYPE_BOOT), relpage_q[11:8]};
            HDR2:    TXDATA = relpage_q[7:0];
            PAY:     TXDATA = byte_q;
            CSUM:    TXDATA = csum_q;
            default: TXVALID = 1'b0;
        endcase
    end

    assign BUSY    = (state_q != IDLE);
    assign OVERRUN = overrun_q;

endmodule

// File: tb/tb_fifo_frame_streamer.sv
// Randomised self-checking bench: a frame-level queue model predicts every byte,
// BUSY and OVERRUN, with literal checks pinning the documented example streams.
module tb_fifo_frame_streamer;

    logic        MCLK = 1'b0;
    logic        RST = 1'b1;
    logic        nWR = 1'b1;
    logic [12:0] waddr = 13'd0;
    logic        wdata = 1'b0;
    logic        nB = 1'b1;
    logic        nU = 1'b1;
    logic [11:0] rp = 12'd0;
    logic        ready = 1'b0;
    logic [7:0]  txdata;
    logic        txvalid, busy, overrun;

    fifo_frame_streamer #(.BOOT_BYTES(1024), .USER_BYTES(64)) dut (
        .MCLK(MCLK), .RST(RST),
        .nFIFOBUFWRCLKEN(nWR), .FIFOBUFWRADDR(waddr), .FIFOBUFWRDATA(wdata),
        .nFIFOSENDBOOT(nB), .nFIFOSENDUSER(nU), .FIFORELPAGE(rp),
        .TXDATA(txdata), .TXVALID(txvalid), .TXREADY(ready),
        .BUSY(busy), .OVERRUN(overrun)
    );

    always #5 MCLK = ~MCLK;

    int checks = 0;
    int errors = 0;

    bit          model_mem [8192];
    byte unsigned exp_q[$];
    byte unsigned cap[$];
    byte unsigned ref1[$];
    int          exp_pos = 0;
    int          gap = 0;
    int          busy_falls = 0;
    bit          m_busy = 0, m_ovr = 0, m_prevb = 1, m_prevu = 1;
    bit          prev_stall = 0, prev_rst = 1, prev_busy_obs = 0;
    byte unsigned prev_data = 0;
    bit          rand_mode = 0, ready_level = 1;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endfunction

    // Frame = sync, type/page high, page low, payload (LSB-first bits), mod-256 sum.
    function automatic void build_frame(bit user, logic [11:0] page);
        int len;
        byte unsigned b, sum;
        len = user ? 64 : 1024;
        sum = 0;
        exp_q.push_back(8'hA5);
        exp_q.push_back({(user ? 4'h1 : 4'h0), page[11:8]});
        exp_q.push_back(page[7:0]);
        for (int k = 0; k < len; k++) begin
            b = 0;
            for (int i = 0; i < 8; i++) b[i] = model_mem[8*k+i];
            exp_q.push_back(b);
            sum = sum + b;
        end
        exp_q.push_back(sum);
    endfunction

    always @(posedge MCLK) begin
        #1;
        ready = rand_mode ? ($urandom_range(0, 99) < 30) : ready_level;
    end

    // Compare outputs against the model, then advance the model across the coming edge.
    always @(negedge MCLK) begin
        bit rb, ru, hsk, was_busy;
        int limit;
        chk("busy", busy, m_busy);
        chk("overrun", overrun, m_ovr);
        if (!m_busy) begin
            chk("valid_idle", txvalid, 1'b0);
        end else if (txvalid === 1'b1) begin
            chk("txdata", txdata, exp_q[0]);
            gap = 0;
        end else begin
            gap++;
            limit = (exp_pos < 3) ? 0 : ((exp_q.size() == 1) ? 1 : 10);
            checks++;
            if (gap > limit) begin
                errors++;
                $display("FAIL byte_gap actual=%0d cycles required<=%0d at frame byte %0d", gap, limit, exp_pos);
            end
        end
        if (prev_stall && !prev_rst) begin
            chk("stall_valid", txvalid, 1'b1);
            chk("stall_data", txdata, prev_data);
        end
        if (prev_busy_obs && !busy) busy_falls++;
        prev_busy_obs = busy;
        prev_stall = txvalid && !ready;
        prev_data  = txdata;
        prev_rst   = RST;

        if (RST) begin
            exp_q.delete();
            m_busy = 0; m_ovr = 0; m_prevb = 1; m_prevu = 1; gap = 0;
        end else begin
            if (!nWR) model_mem[waddr] = wdata;
            rb = !nB && m_prevb;
            ru = !nU && m_prevu;
            hsk = txvalid && ready;
            was_busy = m_busy;
            if (rb || ru) begin
                if (m_busy) m_ovr = 1;
                else begin
                    if (rb && ru) m_ovr = 1;
                    build_frame(!rb, rp);
                    exp_pos = 0; gap = 0; m_busy = 1;
                end
            end
            if (hsk && was_busy && exp_q.size() > 0) begin
                cap.push_back(txdata);
                void'(exp_q.pop_front());
                exp_pos++;
                if (exp_q.size() == 0) m_busy = 0;
            end
            m_prevb = nB;
            m_prevu = nU;
        end
    end

    task automatic send(bit user, bit both, logic [11:0] page, int hold);
        @(posedge MCLK); #1;
        rp = page;
        if (user || both) nU = 0;
        if (!user || both) nB = 0;
        repeat (hold) @(posedge MCLK);
        #1;
        nU = 1; nB = 1;
    endtask

    task automatic wait_done(int budget);
        int n = 0;
        do begin
            @(negedge MCLK);
            n++;
        end while ((busy || m_busy) && n < budget);
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL frame_timeout actual=%0d cycles required<%0d", n, budget);
        end
    endtask

    task automatic wait_cap(int count, int budget);
        int n = 0;
        while (cap.size() < count && n < budget) begin
            @(negedge MCLK);
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL cap_timeout actual=%0d bytes required=%0d", cap.size(), count);
        end
    endtask

    task automatic reset_dut();
        @(posedge MCLK); #1 RST = 1;
        @(posedge MCLK); #1 RST = 0;
    endtask

    function automatic int mism_vs_ref();
        int m = 0;
        for (int i = 0; i < ref1.size(); i++) begin
            if (i >= cap.size() || cap[i] != ref1[i]) m++;
        end
        return m;
    endfunction

    function automatic logic [31:0] cap_at(int i);
        return (i < cap.size()) ? {24'd0, cap[i]} : 32'hFFFF_FFFF;
    endfunction

    initial begin
        repeat (2) @(posedge MCLK);
        #1 RST = 0;
        @(negedge MCLK);
        chk("rst_txvalid", txvalid, 1'b0);
        chk("rst_txdata", txdata, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_overrun", overrun, 1'b0);

        // Ascending page: byte k holds k, so bit a = bit (a%8) of a/8.
        for (int a = 0; a < 512; a++) begin
            @(posedge MCLK); #1;
            nWR = 0; waddr = 13'(a); wdata = ((a >> 3) >> (a & 7)) & 1;
        end
        @(posedge MCLK); #1 nWR = 1;

        cap.delete();
        send(1, 0, 12'h123, 1);
        wait_done(2000);
        chk("t1_len", cap.size(), 68);
        chk("t1_b0", cap_at(0), 8'hA5);
        chk("t1_b1", cap_at(1), 8'h11);
        chk("t1_b2", cap_at(2), 8'h23);
        chk("t1_b3", cap_at(3), 8'h00);
        chk("t1_b66", cap_at(66), 8'h3F);
        chk("t1_csum", cap_at(67), 8'hE0);
        ref1 = cap;

        // Random 30% ready with unrelated high-address writes in flight.
        rand_mode = 1;
        cap.delete();
        send(1, 0, 12'h123, 1);
        fork
            wait_done(8000);
            begin
                for (int j = 0; j < 200; j++) begin
                    @(posedge MCLK); #1;
                    nWR = 0; waddr = 13'(4096 + $urandom_range(0, 4095)); wdata = 1'($urandom);
                end
                @(posedge MCLK); #1 nWR = 1;
            end
        join
        rand_mode = 0;
        chk("t2_len", cap.size(), 68);
        chk("t2_mism", mism_vs_ref(), 0);
        chk("t2_overrun", overrun, 1'b0);

        // Second request during payload is dropped.
        cap.delete();
        send(1, 0, 12'h123, 1);
        wait_cap(20, 1000);
        send(1, 0, 12'h456, 1);
        wait_done(2000);
        chk("t3_len", cap.size(), 68);
        chk("t3_mism", mism_vs_ref(), 0);
        chk("t3_overrun", overrun, 1'b1);

        // Long-held strobe gives exactly one frame.
        reset_dut();
        @(negedge MCLK);
        chk("t4_overrun_clr", overrun, 1'b0);
        busy_falls = 0;
        cap.delete();
        send(1, 0, 12'h123, 100);
        wait_done(2000);
        repeat (20) @(negedge MCLK);
        chk("t4_frames", busy_falls, 1);
        chk("t4_len", cap.size(), 68);

        // Reset mid-payload, then a clean frame.
        cap.delete();
        send(1, 0, 12'h123, 1);
        wait_cap(13, 1000);
        reset_dut();
        @(negedge MCLK);
        chk("t5_valid", txvalid, 1'b0);
        chk("t5_busy", busy, 1'b0);
        cap.delete();
        send(1, 0, 12'h123, 1);
        wait_done(2000);
        chk("t5_len", cap.size(), 68);
        chk("t5_b0", cap_at(0), 8'hA5);
        chk("t5_mism", mism_vs_ref(), 0);

        // All-ones memory, boot frame.
        for (int a = 0; a < 8192; a++) begin
            @(posedge MCLK); #1;
            nWR = 0; waddr = 13'(a); wdata = 1;
        end
        @(posedge MCLK); #1 nWR = 1;
        cap.delete();
        send(0, 0, 12'h000, 1);
        wait_done(15000);
        chk("t6_len", cap.size(), 1028);
        chk("t6_b1", cap_at(1), 8'h00);
        chk("t6_b2", cap_at(2), 8'h00);
        chk("t6_b3", cap_at(3), 8'hFF);
        chk("t6_b1026", cap_at(1026), 8'hFF);
        chk("t6_csum", cap_at(1027), 8'h00);

        // Both strobes in one cycle: boot wins, overrun flagged.
        reset_dut();
        cap.delete();
        send(0, 1, 12'h5A7, 1);
        wait_done(15000);
        chk("t7_len", cap.size(), 1028);
        chk("t7_b1", cap_at(1), 8'h05);
        chk("t7_b2", cap_at(2), 8'hA7);
        chk("t7_overrun", overrun, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
